// File: rtl/mdu_iter_if.sv
// Handshake and result bundle between the execute stage and the
// iterative multiply/divide unit.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] busmult;

  modport master (
    output start, op, a, b,
    input  busy, done, busmult
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, busmult
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit feeding the HI/LO register pair.
// One iteration per cycle for WIDTH cycles, then a one-cycle done pulse
// with {HI,LO} on busmult.
//
//   state  | meaning
//   S_IDLE | waiting for start; busmult holds last result
//   S_RUN  | iterating, busy=1, counter 0..WIDTH-1
//   S_DONE | result just written to busmult, done=1 for one cycle
//
// op encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
// (op[1] selects divide, op[0] selects unsigned).
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic      i_clk,
  input  logic      i_rst,
  mdu_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [WIDTH-1:0]   r_a_orig;
  logic               r_is_div;
  logic               r_signed;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_div0;
  logic [2*WIDTH-1:0] r_busmult;

  logic               w_accept;
  logic               w_last;
  logic               w_op_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_rem;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_neg;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [2*WIDTH-1:0] w_result;

  // Start is only honoured outside RUN; a start during RUN leaves operands alone.
  assign w_accept    = bus.start && (r_state != S_RUN);
  assign w_last      = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_op_signed = ~bus.op[0];
  assign w_abs_a     = (w_op_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign w_abs_b     = (w_op_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = (r_state == S_DONE);
  assign bus.busmult = r_busmult;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode: IDLE -> RUN -> DONE -> IDLE, with restart from DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract
  // for divide. Accumulator is {hi, lo}; for divide that is {R, Q}.
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    if (r_acc[0]) w_mul_sum = w_mul_sum + {1'b0, r_mag_a};
    w_div_rem = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_ge  = (w_div_rem >= {1'b0, r_mag_b});
    if (r_is_div) begin
      if (w_div_ge) begin
        w_div_rem = w_div_rem - {1'b0, r_mag_b};
      end
      w_acc_nxt = {w_div_rem[WIDTH-1:0], r_acc[WIDTH-2:0], w_div_ge};
    end else begin
      w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up on the final iteration. Divide by zero bypasses the
  // datapath so the remainder is exactly the original dividend.
  always_comb begin
    w_neg = r_signed && (r_sign_a ^ r_sign_b);
    w_q   = w_acc_nxt[WIDTH-1:0];
    w_r   = w_acc_nxt[2*WIDTH-1:WIDTH];
    if (w_neg)                 w_q = ~w_q + 1'b1;
    if (r_signed && r_sign_a)  w_r = ~w_r + 1'b1;
    if (r_is_div) begin
      if (r_div0) w_result = {r_a_orig, {WIDTH{1'b1}}};
      else        w_result = {w_r, w_q};
    end else begin
      w_result = w_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    end
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_a_orig  <= '0;
      r_is_div  <= 1'b0;
      r_signed  <= 1'b0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_div0    <= 1'b0;
      r_busmult <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= bus.op[1];
      r_signed <= w_op_signed;
      r_sign_a <= w_op_signed && bus.a[WIDTH-1];
      r_sign_b <= w_op_signed && bus.b[WIDTH-1];
      r_a_orig <= bus.a;
      r_mag_a  <= w_abs_a;
      r_mag_b  <= w_abs_b;
      r_div0   <= bus.op[1] && (bus.b == '0);
      r_acc    <= bus.op[1] ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= w_acc_nxt;
      if (w_last) r_busmult <= w_result;
    end
  end

endmodule
